ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Control-step sequencer that drives the CPU `data_path` register-transfer strobes. It fetches an instruction through MAR/MDR and loads IR. It then steps through the execute phase for register-register ALU, MUL/DIV, unary, NOP and HALT instructions. It sits directly upstream of `data_path` and replaces hand-sequenced bench stimulus with a real T-state machine.

## Interface
Parameters:
- `OPW`, 5, width of opcode and ALU function select
- `RW`, 32, instruction/register width

Ports:
- `Clock`  in  1  single clock; all state changes on posedge
- `clear`  in  1  reset, synchronous, active-high
- `run`  in  1  fetch enable, sampled only in T0
- `mem_ready`  in  1  memory read data valid on `Mdatain` this cycle
- `IR`  in  RW  instruction register contents from `data_path`
- `PCout, Zlowout, Zhighout, MDRout`  out  1 each  bus source strobes
- `MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read`  out  1 each  load/control strobes
- `Gra, Grb, Grc`  out  1 each  register field select (IR Ra/Rb/Rc)
- `Rin, Rout`  out  1 each  selected general register load / drive
- `op`  out  OPW  ALU function select
- `halted`  out  1  high while in HALT
- `illegal`  out  1  one-cycle pulse on undefined opcode

## Operation
- Instruction fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- States: T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a function of registered state plus decoded IR only.
- Strobes not listed for a state are 0. `op` is 0 except where listed.
- T0: if `run`=1, assert PCout, MARin, IncPC, Zin, then go to T1. If `run`=0, assert nothing and stay in T0.
- T1: assert Zlowout and Read every cycle. On `mem_ready`=0, hold in T1 with Read only. On `mem_ready`=1, also assert PCin and MDRin, then go to T2.
- T2: MDRout, IRin, then go to T3.
- Decode in T3 from IR (valid after T2 edge):
- ALU 3-operand (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL):
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, op=alu(opcode), Zin
  - T5: Zlowout, Gra, Rin, then go to T0
- MUL/DIV:
  - T3: Gra, Rout, Yin
  - T4: Grb, Rout, op, Zin
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin, then go to T0
- NOT/NEG:
  - T3: Grb, Rout, op, Zin
  - T4: Zlowout, Gra, Rin, then go to T0
- NOP: T3 asserts nothing, then go to T0.
- HALT: T3 goes to HALT. `halted`=1, no strobes. Only `clear` exits.
- Undefined opcode: `illegal`=1 for the T3 cycle, behaves as NOP.
- `alu(opcode)` mapping lives in the package; AND maps to 5'b00001.

## Timing
- Reset: on a posedge with `clear`=1, state becomes T0. From the following cycle, all outputs are 0 (strobes, `op`, `halted`, `illegal`). This takes priority over `run`/`mem_ready`.
- `clear` mid-instruction aborts it; no partially issued strobe sequence resumes.
- Strobes are stable for the full cycle after the state edge; `data_path` captures on the next posedge.
- Latency with `mem_ready` high in the first T1 cycle:
  - ALU: 6 cycles
  - MUL/DIV: 7 cycles
  - NOT/NEG: 5 cycles
  - NOP/illegal: 4 cycles
- Each T1 wait cycle adds 1.
- PCin and MDRin are asserted for exactly one cycle per fetch, regardless of wait length.
- `run` deasserted outside T0 has no effect; the current instruction completes.

## Structure
- Package `cpu_ctrl_pkg`:
  - opcode constants (ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011)
  - ALU function constants
  - state encoding
  - `alu()` mapping function
- Optional sub-module `op_decode`: combinational opcode → {class, alu op, illegal}. Sequencer FSM and strobe logic stay in `ctrl_sequencer`.

## Test plan
- `clear`=1 for 2 cycles, `run`=1 → all outputs 0 during reset; T0 strobes (PCout, MARin, IncPC, Zin) in the first cycle after release.
- IR=AND R1,R2,R3 (opcode 00101, Ra=1, Rb=2, Rc=3), `mem_ready`=1 → exact 6-cycle strobe trace; `op`=5'b00001 only in T4; Gra+Rin only in T5.
- Same fetch with `mem_ready` low for 3 cycles → Read high 4 cycles; PCin/MDRin high only in the 4th.
- MUL → LOin in T5, HIin in T6, back to T0 after 7 cycles. NOT → 5 cycles, Yin never asserted.
- Opcode 11111 → `illegal` pulses once in T3, next state T0. HALT opcode → `halted`=1 stays for 10 cycles; `clear` → T0 next cycle.
- `run`=0 in T0 → no strobes for N cycles. `clear` asserted during T4 of an ALU op → Rin never asserted; state T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, ALU function codes,
// T-state encoding, opcode classes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_ROR  = 5'b01001;
  localparam logic [4:0] OPC_ROL  = 5'b01010;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // ALU function select codes understood by data_path
  localparam logic [4:0] ALU_AND = 5'b00001;
  localparam logic [4:0] ALU_OR  = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_SHR = 5'b00101;
  localparam logic [4:0] ALU_SHL = 5'b00110;
  localparam logic [4:0] ALU_ROR = 5'b00111;
  localparam logic [4:0] ALU_ROL = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b01001;
  localparam logic [4:0] ALU_DIV = 5'b01010;
  localparam logic [4:0] ALU_NEG = 5'b01011;
  localparam logic [4:0] ALU_NOT = 5'b01100;

  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_HALT
  } op_class_e;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic halted;
    logic illegal;
  } strobes_t;

  function automatic logic [4:0] alu(input logic [4:0] opcode);
    case (opcode)
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      OPC_SHR: return ALU_SHR;
      OPC_SHL: return ALU_SHL;
      OPC_ROR: return ALU_ROR;
      OPC_ROL: return ALU_ROL;
      OPC_MUL: return ALU_MUL;
      OPC_DIV: return ALU_DIV;
      OPC_NEG: return ALU_NEG;
      OPC_NOT: return ALU_NOT;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decode: instruction class, ALU function and illegal flag.
module op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output logic [4:0] alu_op,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_NOP;
    illegal  = 1'b0;
    alu_op   = alu(opcode);
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: op_class = CLS_ALU;
      OPC_MUL, OPC_DIV:                   op_class = CLS_MULDIV;
      OPC_NEG, OPC_NOT:                   op_class = CLS_UNARY;
      OPC_NOP:                            op_class = CLS_NOP;
      OPC_HALT:                           op_class = CLS_HALT;
      default:                            illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// T-state control sequencer driving data_path register-transfer strobes:
// fetch through MAR/MDR into IR, then per-class execute steps.
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5,
  parameter int RW  = 32
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic           run,
  input  logic           mem_ready,
  input  logic [RW-1:0]  IR,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] op,
  output logic           halted,
  output logic           illegal
);

  state_e    state_q, state_d;
  strobes_t  strb_c, strb;
  logic [4:0] op_c;
  op_class_e dec_class;
  logic [4:0] dec_alu;
  logic      dec_illegal;
  logic      unused_ir;

  assign unused_ir = ^IR;

  op_decode u_op_decode (
    .opcode   (IR[31:27]),
    .op_class (dec_class),
    .alu_op   (dec_alu),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge Clock) begin
    if (clear) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    strb_c  = '0;
    op_c    = '0;
    case (state_q)
      ST_T0: if (run) begin
        strb_c.pc_out = 1'b1; strb_c.mar_in = 1'b1;
        strb_c.inc_pc = 1'b1; strb_c.z_in   = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        strb_c.zlow_out = 1'b1; strb_c.read = 1'b1;
        // PC/MDR load only on the ready cycle so a long wait loads them once
        if (mem_ready) begin
          strb_c.pc_in = 1'b1; strb_c.mdr_in = 1'b1;
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        strb_c.mdr_out = 1'b1; strb_c.ir_in = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (dec_class)
          CLS_ALU:    begin strb_c.grb = 1'b1; strb_c.r_out = 1'b1; strb_c.y_in = 1'b1; end
          CLS_MULDIV: begin strb_c.gra = 1'b1; strb_c.r_out = 1'b1; strb_c.y_in = 1'b1; end
          CLS_UNARY: begin
            strb_c.grb = 1'b1; strb_c.r_out = 1'b1; strb_c.z_in = 1'b1;
            op_c = dec_alu;
          end
          CLS_HALT: state_d = ST_HALT;
          default: begin
            strb_c.illegal = dec_illegal;
            state_d = ST_T0;
          end
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (dec_class)
          CLS_ALU: begin
            strb_c.grc = 1'b1; strb_c.r_out = 1'b1; strb_c.z_in = 1'b1;
            op_c = dec_alu;
          end
          CLS_MULDIV: begin
            strb_c.grb = 1'b1; strb_c.r_out = 1'b1; strb_c.z_in = 1'b1;
            op_c = dec_alu;
          end
          CLS_UNARY: begin
            strb_c.zlow_out = 1'b1; strb_c.gra = 1'b1; strb_c.r_in = 1'b1;
            state_d = ST_T0;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T5: begin
        state_d = ST_T0;
        case (dec_class)
          CLS_ALU: begin
            strb_c.zlow_out = 1'b1; strb_c.gra = 1'b1; strb_c.r_in = 1'b1;
          end
          CLS_MULDIV: begin
            strb_c.zlow_out = 1'b1; strb_c.lo_in = 1'b1;
            state_d = ST_T6;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        strb_c.zhigh_out = 1'b1; strb_c.hi_in = 1'b1;
        state_d = ST_T0;
      end
      ST_HALT: strb_c.halted = 1'b1;
      default: state_d = ST_T0;
    endcase
  end

  // clear silences every output immediately, including T0's run-driven strobes
  assign strb = clear ? '0 : strb_c;
  assign op   = clear ? '0 : OPW'(op_c);

  assign PCout    = strb.pc_out;
  assign Zlowout  = strb.zlow_out;
  assign Zhighout = strb.zhigh_out;
  assign MDRout   = strb.mdr_out;
  assign MARin    = strb.mar_in;
  assign PCin     = strb.pc_in;
  assign MDRin    = strb.mdr_in;
  assign IRin     = strb.ir_in;
  assign Yin      = strb.y_in;
  assign Zin      = strb.z_in;
  assign HIin     = strb.hi_in;
  assign LOin     = strb.lo_in;
  assign IncPC    = strb.inc_pc;
  assign Read     = strb.read;
  assign Gra      = strb.gra;
  assign Grb      = strb.grb;
  assign Grc      = strb.grc;
  assign Rin      = strb.r_in;
  assign Rout     = strb.r_out;
  assign halted   = strb.halted;
  assign illegal  = strb.illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed instruction table, hand-written
// clear/halt sequences and random instructions against a per-cycle trace model.
module tb_ctrl_sequencer;

  logic        Clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, halted, illegal;
  logic [4:0] op;

  ctrl_sequencer #(.OPW(5), .RW(32)) dut (
    .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .op(op), .halted(halted), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
    logic y_in, z_in, hi_in, lo_in, inc_pc, read, gra, grb, grc, r_in, r_out;
    logic halted, illegal;
    logic [4:0] op;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          idle;
    int          exp_len;
    string       name;
  } vec_t;

  obs_t act_w;
  assign act_w = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                  Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                  halted, illegal, op};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam int K_ALU = 0, K_MULDIV = 1, K_UNARY = 2, K_NOP = 3, K_HALT = 4, K_ILL = 5;

  function automatic int kind_of(input logic [4:0] opc);
    if (opc >= 5'd3 && opc <= 5'd10) return K_ALU;
    if (opc == 5'd15 || opc == 5'd16) return K_MULDIV;
    if (opc == 5'd17 || opc == 5'd18) return K_UNARY;
    if (opc == 5'd26) return K_NOP;
    if (opc == 5'd27) return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic [4:0] alu_ref(input logic [4:0] opc);
    logic [4:0] tbl [0:31];
    for (int i = 0; i < 32; i++) tbl[i] = 5'd0;
    tbl[3] = 5'd3;  tbl[4] = 5'd4;  tbl[5] = 5'd1;  tbl[6] = 5'd2;
    tbl[7] = 5'd5;  tbl[8] = 5'd6;  tbl[9] = 5'd7;  tbl[10] = 5'd8;
    tbl[15] = 5'd9; tbl[16] = 5'd10; tbl[17] = 5'd11; tbl[18] = 5'd12;
    return tbl[opc];
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    logic [14:0] low;
    low = 15'($urandom);
    return {opc, ra, rb, rc, low};
  endfunction

  task automatic step(input logic r, input logic m, input logic c, input obs_t e,
                      input string nm);
    run = r; mem_ready = m; clear = c;
    @(negedge Clock);
    checks++;
    if (act_w !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act_w, e);
    end
    @(posedge Clock); #1;
    cyc++;
  endtask

  task automatic do_instr(input logic [31:0] ir, input int waits, input int idle,
                          input string nm, output int ncyc);
    obs_t q[$];
    obs_t e;
    int   k;
    logic m;
    k = kind_of(ir[31:27]);
    IR = $urandom;
    for (int i = 0; i < idle; i++) step(1'b0, 1'($urandom), 1'b0, '0, {nm, "_idle"});
    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; q.push_back(e);
    for (int i = 0; i < waits; i++) begin
      e = '0; e.read = 1; e.zlow_out = 1; q.push_back(e);
    end
    e = '0; e.read = 1; e.zlow_out = 1; e.pc_in = 1; e.mdr_in = 1; q.push_back(e);
    e = '0; e.mdr_out = 1; e.ir_in = 1; q.push_back(e);
    case (k)
      K_ALU: begin
        e = '0; e.grb = 1; e.r_out = 1; e.y_in = 1; q.push_back(e);
        e = '0; e.grc = 1; e.r_out = 1; e.z_in = 1; e.op = alu_ref(ir[31:27]); q.push_back(e);
        e = '0; e.zlow_out = 1; e.gra = 1; e.r_in = 1; q.push_back(e);
      end
      K_MULDIV: begin
        e = '0; e.gra = 1; e.r_out = 1; e.y_in = 1; q.push_back(e);
        e = '0; e.grb = 1; e.r_out = 1; e.z_in = 1; e.op = alu_ref(ir[31:27]); q.push_back(e);
        e = '0; e.zlow_out = 1; e.lo_in = 1; q.push_back(e);
        e = '0; e.zhigh_out = 1; e.hi_in = 1; q.push_back(e);
      end
      K_UNARY: begin
        e = '0; e.grb = 1; e.r_out = 1; e.z_in = 1; e.op = alu_ref(ir[31:27]); q.push_back(e);
        e = '0; e.zlow_out = 1; e.gra = 1; e.r_in = 1; q.push_back(e);
      end
      K_ILL: begin
        e = '0; e.illegal = 1; q.push_back(e);
      end
      default: q.push_back('0);
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (i >= 1 && i <= waits) m = 1'b0;
      else if (i == waits + 1) m = 1'b1;
      else m = 1'($urandom);
      step((i == 0) ? 1'b1 : 1'($urandom), m, 1'b0, q[i], nm);
      if (i == waits + 2) IR = ir;   // data_path captures IR on the IRin edge
    end
    ncyc = q.size();
    if (k == K_HALT) begin
      e = '0; e.halted = 1;
      for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), 1'b0, e, "halt_hold");
      step(1'($urandom), 1'($urandom), 1'b1, '0, "halt_clear");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    obs_t e;
    int   n;
    logic [4:0] legal [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                               5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
    logic [4:0] opc;

    vecs[0]  = '{mk_ir(5'b00101, 4'd1, 4'd2, 4'd3), 0, 0, 6, "and"};
    vecs[1]  = '{mk_ir(5'b00101, 4'd1, 4'd2, 4'd3), 3, 0, 9, "and_wait3"};
    vecs[2]  = '{mk_ir(5'b01111, 4'd4, 4'd5, 4'd0), 0, 0, 7, "mul"};
    vecs[3]  = '{mk_ir(5'b10010, 4'd6, 4'd7, 4'd0), 0, 0, 5, "not"};
    vecs[4]  = '{mk_ir(5'b11111, 4'd0, 4'd0, 4'd0), 0, 0, 4, "illegal"};
    vecs[5]  = '{mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 5, 4, "nop_idle"};
    vecs[6]  = '{mk_ir(5'b10000, 4'd2, 4'd3, 4'd0), 1, 0, 8, "div_wait1"};
    vecs[7]  = '{mk_ir(5'b00100, 4'd8, 4'd9, 4'd10), 2, 0, 8, "sub_wait2"};
    vecs[8]  = '{mk_ir(5'b10001, 4'd11, 4'd12, 4'd0), 0, 0, 5, "neg"};
    vecs[9]  = '{mk_ir(5'b01010, 4'd13, 4'd14, 4'd15), 0, 1, 6, "rol"};
    vecs[10] = '{mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 0, 4, "halt"};

    clear = 1'b1; run = 1'b1; mem_ready = 1'b0; IR = '0;
    step(1'b1, 1'b0, 1'b1, '0, "reset_0");
    step(1'b1, 1'b1, 1'b1, '0, "reset_1");

    foreach (vecs[i]) begin
      do_instr(vecs[i].ir, vecs[i].waits, vecs[i].idle, vecs[i].name, n);
      checks++;
      if (n != vecs[i].exp_len) begin
        failures++;
        $display("FAIL %s_latency actual=%0d expected=%0d", vecs[i].name, n, vecs[i].exp_len);
      end
    end

    // clear during T4 of an ALU op: the write-back T5 must never happen
    IR = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    step(1'b1, 1'b0, 1'b0, e, "abort_t0");
    e = '0; e.read = 1; e.zlow_out = 1; e.pc_in = 1; e.mdr_in = 1;
    step(1'b0, 1'b1, 1'b0, e, "abort_t1");
    e = '0; e.mdr_out = 1; e.ir_in = 1;
    step(1'b0, 1'b0, 1'b0, e, "abort_t2");
    e = '0; e.grb = 1; e.r_out = 1; e.y_in = 1;
    step(1'b0, 1'b0, 1'b0, e, "abort_t3");
    step(1'b1, 1'b1, 1'b1, '0, "abort_clear");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, "abort_after");
    do_instr(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0, "post_abort", n);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 8) opc = legal[$urandom_range(0, 13)];
      else opc = 5'($urandom);
      do_instr(mk_ir(opc, 4'($urandom), 4'($urandom), 4'($urandom)),
               $urandom_range(0, 4), $urandom_range(0, 2), "random", n);
    end
    do_instr(mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), 0, 0, "final_nop", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
